mix_col_iter: RTL
=================

MIX_COL_ITER -- requirements
Module: mix_col_iter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock port `clk`, reset port `rst`.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Synchronous active-high reset.
REQ-004 in_valid  input  1  The 128-bit input block is valid.
REQ-005 in_ready  output  1  The block accepts input this cycle.
REQ-006 data_in  input  128  AES state, column-major.
  - Column c occupies bits [127-32c : 96-32c].
  - Row 0 of each column is the most significant byte.
REQ-007 out_valid  output  1  The data_out result is valid.
REQ-008 out_ready  input  1  The downstream stage accepts the result.
REQ-009 data_out  output  128  Transformed state, same byte layout as data_in.
REQ-010 inv  input  1  Present only when MIX_COL_INV_EN is defined.
  - 1 = InvMixColumns, 0 = MixColumns.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
REQ-013 An accept occurs on an edge where in_valid=1 and in_ready=1. On that edge the block SHALL:
  - capture data_in into the internal state register;
  - clear the 2-bit column counter to 0;
  - move to BUSY.
REQ-014 Each BUSY edge SHALL replace column[counter] with its MixColumns transform and increment the counter.
  - GF(2^8) multiply-by-2 uses reduction polynomial 0x11B.
  - Transform: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-015 On the BUSY edge that processes column 3, the counter SHALL wrap to 0 and the FSM SHALL move to DONE.
  - out_valid is therefore first high 4 edges after the accept edge.
REQ-016 data_out SHALL be driven directly from the state register and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 In DONE, an edge with out_ready=1 SHALL move the FSM to IDLE.
  - data_out keeps its last value.
  - in_ready rises the following cycle.
  - Throughput is at most one block per 6 cycles.
REQ-018 in_valid and data_in SHALL be ignored in BUSY and DONE.
  - Changes to data_in after the accept edge SHALL NOT affect the result.
REQ-019 out_ready SHALL be ignored outside DONE.

Reset
REQ-020 While rst=1 at an edge, the block SHALL:
  - enter IDLE;
  - clear the counter;
  - clear the state register, so data_out=0;
  - drive out_valid=0 and in_ready=1 from the next cycle.
REQ-021 Reset asserted in BUSY or DONE SHALL abandon the block in flight with no output produced.
  - A simultaneous in_valid is not accepted on that edge.

Configuration
REQ-022 Macro MIX_COL_INV_EN SHALL compile in the `inv` port and inverse mode.
REQ-023 With the macro defined:
  - `inv` is sampled at the accept edge and held in a mode register for the whole block.
  - When the mode register is 1, each BUSY edge SHALL first pre-condition the column, then apply the REQ-014 transform.
  - Pre-conditioning: u=4(a0^a2), v=4(a1^a3); a0^=u, a1^=v, a2^=u, a3^=v.
  - Result is the exact InvMixColumns transform (14/11/13/9 matrix); latency is unchanged.
REQ-024 Without the macro:
  - the `inv` port and mode register SHALL be absent;
  - the block performs MixColumns only.

Verification
REQ-025 Single block: data_in=db135345_f20a225c_01010101_c6c6c6c6 accepted -> after exactly 4 edges out_valid=1, data_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-026 Backpressure: data_in=d4d4d4d5_2d26314c_00000000_ffffffff with out_ready=0 for 10 cycles -> the following all hold stable until out_ready=1:
  - data_out=d5d5d7d6_4d7ebdf8_00000000_ffffffff;
  - out_valid=1;
  - in_ready=0.
REQ-027 Ignored input: toggle in_valid and data_in every cycle during BUSY -> result unchanged from REQ-025; exactly one output per accept.
REQ-028 Reset mid-operation: rst=1 on the 2nd BUSY edge -> next cycle out_valid=0, in_ready=1, data_out=0; a new block then completes correctly.
REQ-029 (MIX_COL_INV_EN) inv=1 with data_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> data_out=db135345_f20a225c_01010101_c6c6c6c6.
  - A back-to-back forward/inverse pair with random data SHALL return the original data.

Source files
------------

// File: rtl/mix_col_iter.sv
// Iterative AES MixColumns: one 32-bit column per clock, four clocks per block.
// Define MIX_COL_INV_EN to add the `inv` port and InvMixColumns mode.
module mix_col_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef MIX_COL_INV_EN
    input  logic         inv,
`endif
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
`ifdef MIX_COL_INV_EN
    logic         inv_q, inv_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

`ifdef MIX_COL_INV_EN
    // Folding 4*(a0^a2) and 4*(a1^a3) in turns the forward matrix into 14/11/13/9.
    function automatic logic [31:0] inv_precond(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, u, v;
        {a0, a1, a2, a3} = col;
        u = xtime(xtime(a0 ^ a2));
        v = xtime(xtime(a1 ^ a3));
        return {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
    endfunction
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef MIX_COL_INV_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
`ifdef MIX_COL_INV_EN
                    inv_d   = inv;
`endif
                end
            end
            BUSY: begin
                for (int c = 0; c < 4; c++) begin
                    if (cnt_q == 2'(c)) begin
`ifdef MIX_COL_INV_EN
                        data_d[127-32*c -: 32] = inv_q
                            ? mix_col(inv_precond(data_q[127-32*c -: 32]))
                            : mix_col(data_q[127-32*c -: 32]);
`else
                        data_d[127-32*c -: 32] = mix_col(data_q[127-32*c -: 32]);
`endif
                    end
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            // NOTE: the data register is cleared on reset so data_out reads 0 afterwards.
            data_q  <= '0;
`ifdef MIX_COL_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef MIX_COL_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = data_q;

endmodule
